// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: branch types, hold FSM states,
// and the instruction size used for sequential fetch.
package pc_pkg;

   typedef enum logic [1:0] {
      BT_BEQ = 2'b00,
      BT_BNE = 2'b01,
      BT_BLT = 2'b10,
      BT_BGE = 2'b11
   } branch_type_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam int unsigned INST_BYTES = 4;

endpackage : pc_pkg

// File: rtl/pc_unit_branch_cond.sv
// Combinational taken decode for conditional branches, driven by the ALU flags.
module branch_cond
   import pc_pkg::*;
(
   input  logic       branch_i,
   input  logic [1:0] branch_type_i,
   input  logic       zero_i,
   input  logic       negative_i,
   output logic       taken_o
);

   always_comb begin
      // NOTE: assign a default before any branching so no path leaves taken_o unassigned (no latch).
      taken_o = 1'b0;
      if (branch_i) begin
         case (branch_type_e'(branch_type_i))
            BT_BEQ:  taken_o = zero_i;
            BT_BNE:  taken_o = ~zero_i;
            BT_BLT:  taken_o = negative_i;
            BT_BGE:  taken_o = ~negative_i;
            default: taken_o = 1'b0;
         endcase
      end
   end

endmodule : branch_cond

// File: rtl/pc_unit.sv
// Fetch-address register with branches, jumps, trap entry/return and stall-held redirects.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned redirect targets into traps.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            branch,
   input  logic [1:0]      branch_type,
   input  logic            zero,
   input  logic            negative,
   input  logic [XLEN-1:0] addr_result,
   input  logic            jump,
   input  logic            jump_reg,
   input  logic [XLEN-1:0] reg_target,
   input  logic            trap,
   input  logic            trap_return,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] branch_base_addr,
   output logic [XLEN-1:0] epc,
   output logic            redirect,
   output logic            pending
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic            misaligned
`endif
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] hold_q, hold_d;
   state_e          state_q, state_d;
   logic            redirect_q, redirect_d;

   logic            taken;
   logic            req_valid;
   logic [XLEN-1:0] req_raw;
   logic [XLEN-1:0] req_target;
   logic            trap_take;

   branch_cond u_branch_cond (
      .branch_i      (branch),
      .branch_type_i (branch_type),
      .zero_i        (zero),
      .negative_i    (negative),
      .taken_o       (taken)
   );

   // Highest-priority non-trap redirect; trap itself is handled separately below.
   always_comb begin
      req_valid = trap_return | jump_reg | jump | taken;
      req_raw   = addr_result;
      if (trap_return) begin
         req_raw = epc_q;
      end else if (jump_reg) begin
         req_raw = reg_target;
      end
      req_target = req_raw & ALIGN_MASK;
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic mis_fault;
   logic misaligned_q;

   assign mis_fault  = req_valid & (req_raw[1:0] != 2'b00) & ~trap;
   assign trap_take  = trap | mis_fault;
   assign misaligned = misaligned_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= mis_fault;
      end
   end
`else
   assign trap_take = trap;
`endif

   always_comb begin
      pc_d       = pc_q;
      epc_d      = epc_q;
      hold_d     = hold_q;
      state_d    = state_q;
      redirect_d = 1'b0;
      if (trap_take) begin
         epc_d      = pc_q;
         pc_d       = TRAP_VECTOR;
         state_d    = ST_RUN;
         redirect_d = 1'b1;
      end else if (stall) begin
         // Frozen fetch: remember the newest redirect so it survives the stall.
         if (req_valid) begin
            hold_d  = req_target;
            state_d = ST_HOLD;
         end
      end else if (req_valid) begin
         pc_d       = req_target;
         state_d    = ST_RUN;
         redirect_d = 1'b1;
      end else if (state_q == ST_HOLD) begin
         pc_d       = hold_q;
         state_d    = ST_RUN;
         redirect_d = 1'b1;
      end else begin
         pc_d = pc_q + XLEN'(INST_BYTES);
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         hold_q     <= '0;
         state_q    <= ST_RUN;
         redirect_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         hold_q     <= hold_d;
         state_q    <= state_d;
         redirect_q <= redirect_d;
      end
   end

   assign pc               = pc_q;
   assign branch_base_addr = pc_q;
   assign epc              = epc_q;
   assign redirect         = redirect_q;
   assign pending          = (state_q == ST_HOLD);

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues hand-computed expectations per edge,
// and a monitor pops and compares them just after each rising edge.
module tb_pc_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic [1:0]  branch_type = 2'b00;
   logic        zero = 1'b0;
   logic        negative = 1'b0;
   logic [31:0] addr_result = '0;
   logic        jump = 1'b0;
   logic        jump_reg = 1'b0;
   logic [31:0] reg_target = '0;
   logic        trap = 1'b0;
   logic        trap_return = 1'b0;
   logic [31:0] pc, branch_base_addr, epc;
   logic        redirect, pending;
   logic        exp_mis = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        red;
      logic        pend;
      logic        mis;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   pc_unit dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .stall            (stall),
      .branch           (branch),
      .branch_type      (branch_type),
      .zero             (zero),
      .negative         (negative),
      .addr_result      (addr_result),
      .jump             (jump),
      .jump_reg         (jump_reg),
      .reg_target       (reg_target),
      .trap             (trap),
      .trap_return      (trap_return),
      .pc               (pc),
      .branch_base_addr (branch_base_addr),
      .epc              (epc),
      .redirect         (redirect),
      .pending          (pending)
`ifdef PC_MISALIGN_TRAP_EN
      ,
      .misaligned       (misaligned)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Advance to the next falling edge and return every control input to idle.
   task automatic cyc();
      @(negedge clock);
      reset_n = 1'b1; stall = 1'b0; branch = 1'b0; branch_type = 2'b00;
      zero = 1'b0; negative = 1'b0; addr_result = '0; jump = 1'b0;
      jump_reg = 1'b0; reg_target = '0; trap = 1'b0; trap_return = 1'b0;
      exp_mis = 1'b0;
   endtask

   task automatic expect_after(input logic [31:0] e_pc, input logic [31:0] e_epc,
                               input logic e_red, input logic e_pend, input string name);
      exp_t e;
      e.pc = e_pc; e.epc = e_epc; e.red = e_red; e.pend = e_pend; e.mis = exp_mis; e.name = name;
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, ".pc"}, pc, e.pc);
            check({e.name, ".base"}, branch_base_addr, e.pc);
            check({e.name, ".epc"}, epc, e.epc);
            check({e.name, ".redirect"}, 32'(redirect), 32'(e.red));
            check({e.name, ".pending"}, 32'(pending), 32'(e.pend));
`ifdef PC_MISALIGN_TRAP_EN
            check({e.name, ".misaligned"}, 32'(misaligned), 32'(e.mis));
`endif
         end
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic [31:0] EPC_TAIL = 32'h100;
`else
   localparam logic [31:0] EPC_TAIL = 32'h300;
`endif

   initial begin : driver
      // Reset held for two edges, then free-running fetch.
      cyc(); reset_n = 1'b0; expect_after(32'h0, 32'h0, 0, 0, "reset0");
      cyc(); reset_n = 1'b0; expect_after(32'h0, 32'h0, 0, 0, "reset1");
      cyc(); expect_after(32'h4,  32'h0, 0, 0, "seq4");
      cyc(); expect_after(32'h8,  32'h0, 0, 0, "seq8");
      cyc(); expect_after(32'hC,  32'h0, 0, 0, "seq12");
      cyc(); expect_after(32'h10, 32'h0, 0, 0, "seq16");

      // Branch decode from pc=0x10 toward 0x40.
      cyc(); branch = 1; branch_type = 2'b00; zero = 1; addr_result = 32'h40;
      expect_after(32'h40, 32'h0, 1, 0, "beq_taken");
      cyc(); jump = 1; addr_result = 32'h10; expect_after(32'h10, 32'h0, 1, 0, "jmp10a");
      cyc(); branch = 1; branch_type = 2'b01; zero = 1; addr_result = 32'h40;
      expect_after(32'h14, 32'h0, 0, 0, "bne_not");
      cyc(); jump = 1; addr_result = 32'h10; expect_after(32'h10, 32'h0, 1, 0, "jmp10b");
      cyc(); branch = 1; branch_type = 2'b10; negative = 1; addr_result = 32'h40;
      expect_after(32'h40, 32'h0, 1, 0, "blt_taken");
      cyc(); jump = 1; addr_result = 32'h10; expect_after(32'h10, 32'h0, 1, 0, "jmp10c");
      cyc(); branch = 1; branch_type = 2'b11; negative = 1; addr_result = 32'h40;
      expect_after(32'h14, 32'h0, 0, 0, "bge_not");
      cyc(); branch = 0; branch_type = 2'b00; zero = 1; addr_result = 32'h40;
      expect_after(32'h18, 32'h0, 0, 0, "no_branch");
      cyc(); branch = 1; branch_type = 2'b01; zero = 0; addr_result = 32'h40;
      expect_after(32'h40, 32'h0, 1, 0, "bne_taken");

      // Redirect arriving under stall is held until release.
      cyc(); jump = 1; addr_result = 32'h20; expect_after(32'h20, 32'h0, 1, 0, "jmp20");
      cyc(); stall = 1; jump = 1; addr_result = 32'h80;
      expect_after(32'h20, 32'h0, 0, 1, "stall_jmp");
      for (int i = 0; i < 3; i++) begin
         cyc(); stall = 1; expect_after(32'h20, 32'h0, 0, 1, "stall_hold");
      end
      cyc(); expect_after(32'h80, 32'h0, 1, 0, "stall_release");

      // Last held redirect wins; a live redirect at release beats the held one.
      cyc(); stall = 1; jump = 1; addr_result = 32'h90; expect_after(32'h80, 32'h0, 0, 1, "hold90");
      cyc(); stall = 1; jump = 1; addr_result = 32'hA0; expect_after(32'h80, 32'h0, 0, 1, "holdA0");
      cyc(); expect_after(32'hA0, 32'h0, 1, 0, "last_wins");
      cyc(); stall = 1; jump = 1; addr_result = 32'hB0; expect_after(32'hA0, 32'h0, 0, 1, "holdB0");
      cyc(); jump = 1; addr_result = 32'hC0; expect_after(32'hC0, 32'h0, 1, 0, "live_wins");

      // Trap during HOLD discards the held target.
      cyc(); stall = 1; jump = 1; addr_result = 32'h200; expect_after(32'hC0, 32'h0, 0, 1, "hold200");
      cyc(); stall = 1; trap = 1; expect_after(32'h100, 32'hC0, 1, 0, "trap_in_hold");
      cyc(); expect_after(32'h104, 32'hC0, 0, 0, "after_trap");

      // Trap under stall and return.
      cyc(); jump = 1; addr_result = 32'h34; expect_after(32'h34, 32'hC0, 1, 0, "jmp34");
      cyc(); stall = 1; trap = 1; expect_after(32'h100, 32'h34, 1, 0, "trap_stall");
      cyc(); expect_after(32'h104, 32'h34, 0, 0, "trap_seq");
      cyc(); trap_return = 1; expect_after(32'h34, 32'h34, 1, 0, "trap_ret");

      // Priority.
      cyc(); trap = 1; jump_reg = 1; reg_target = 32'h300; jump = 1; addr_result = 32'h400;
      expect_after(32'h100, 32'h34, 1, 0, "prio_trap");
      cyc(); jump_reg = 1; reg_target = 32'h300; jump = 1; addr_result = 32'h400;
      expect_after(32'h300, 32'h34, 1, 0, "prio_jreg");
      cyc(); trap = 1; trap_return = 1; expect_after(32'h100, 32'h300, 1, 0, "prio_trap_ret");
      cyc(); trap_return = 1; jump_reg = 1; reg_target = 32'h600;
      expect_after(32'h300, 32'h300, 1, 0, "prio_ret_jreg");

      // Misaligned targets.
`ifdef PC_MISALIGN_TRAP_EN
      cyc(); jump_reg = 1; reg_target = 32'h42; exp_mis = 1;
      expect_after(32'h100, 32'h300, 1, 0, "mis_jreg");
      cyc(); jump = 1; addr_result = 32'h57; exp_mis = 1;
      expect_after(32'h100, 32'h100, 1, 0, "mis_jmp");
`else
      cyc(); jump_reg = 1; reg_target = 32'h42; expect_after(32'h40, 32'h300, 1, 0, "mis_jreg");
      cyc(); jump = 1; addr_result = 32'h57; expect_after(32'h54, 32'h300, 1, 0, "mis_jmp");
`endif

      // Wrap at the top of the address space.
      cyc(); jump = 1; addr_result = 32'hFFFF_FFFC; expect_after(32'hFFFF_FFFC, EPC_TAIL, 1, 0, "jmp_top");
      cyc(); expect_after(32'h0, EPC_TAIL, 0, 0, "wrap");

      // Reset wins mid-HOLD.
      cyc(); stall = 1; jump = 1; addr_result = 32'h80; expect_after(32'h0, EPC_TAIL, 0, 1, "hold_pre_rst");
      cyc(); reset_n = 1'b0; stall = 1; jump = 1; addr_result = 32'h80;
      expect_after(32'h0, 32'h0, 0, 0, "reset_in_hold");
      cyc(); expect_after(32'h4, 32'h0, 0, 0, "post_reset");

      cyc();
      repeat (3) @(posedge clock);
      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pc_unit
